// File: rtl/output_drain_scheduler.sv
// Output BRAM drain sequencer: sweeps every filter and BRAM address and streams
// the words to the DRAM writer over valid/ready, at one word per cycle under full ready.
module output_drain_scheduler #(
  parameter int NUMBER_SUPPORTED_FILTERS = 30,
  parameter int N_COLS_ARRAY             = 16,
  parameter int DRAM_ADDR_WIDTH          = 18,
  parameter int BRAM_ADDR_WIDTH          = 11,
  localparam int FW      = $clog2(NUMBER_SUPPORTED_FILTERS),
  localparam int N_BANKS = (NUMBER_SUPPORTED_FILTERS + N_COLS_ARRAY - 1) / N_COLS_ARRAY
) (
  input  logic                       clk_i,
  input  logic                       bram_addr_max_rst,
  input  logic                       start_i,
  input  logic [BRAM_ADDR_WIDTH-1:0] addr_max_i,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_base_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [FW-1:0]              sel_filter_o,
  output logic [N_BANKS-1:0]         bram_rd_en_o,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr_o,
  output logic                       dram_wr_valid_o,
  input  logic                       dram_wr_ready_i,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_wr_addr_o
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FLUSH, DONE} state_t;

  state_t                     state_reg;
  logic [BRAM_ADDR_WIDTH-1:0] addr_reg;
  logic [BRAM_ADDR_WIDTH-1:0] max_reg;
  logic [FW-1:0]              filter_reg;
  logic [31:0]                filter_ext;
  logic                       slot_free;
  logic                       issue;
  logic                       last_addr;
  logic                       last_filter;
  logic                       beat_accepted;

  // The read is issued combinationally so the BRAM word lands in the same
  // cycle the beat register (valid/sel/addr) turns it into a bus beat.
  assign slot_free     = !dram_wr_valid_o || dram_wr_ready_i;
  assign issue         = (state_reg == DRAIN) && slot_free;
  assign last_addr     = (addr_reg == max_reg);
  assign last_filter   = (filter_reg == FW'(NUMBER_SUPPORTED_FILTERS - 1));
  assign beat_accepted = dram_wr_valid_o && dram_wr_ready_i;
  assign filter_ext    = 32'(filter_reg);

  assign bram_rd_addr_o = issue ? addr_reg : '0;

  generate
    for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank_en
      assign bram_rd_en_o[gi] = issue && ((filter_ext / N_COLS_ARRAY) == 32'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or posedge bram_addr_max_rst) begin
    if (bram_addr_max_rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      max_reg         <= '0;
      filter_reg      <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      sel_filter_o    <= '0;
      dram_wr_valid_o <= 1'b0;
      dram_wr_addr_o  <= '0;
    end else begin
      done_o <= 1'b0;

      // Beat register: a new issue refills it, otherwise acceptance empties it.
      if (issue) begin
        dram_wr_valid_o <= 1'b1;
        sel_filter_o    <= filter_reg;
      end else if (dram_wr_ready_i) begin
        dram_wr_valid_o <= 1'b0;
      end

      if (beat_accepted) begin
        dram_wr_addr_o <= dram_wr_addr_o + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg <= LOAD;
            busy_o    <= 1'b1;
          end
        end
        LOAD: begin
          max_reg        <= addr_max_i;
          dram_wr_addr_o <= dram_base_i;
          filter_reg     <= '0;
          addr_reg       <= '0;
          state_reg      <= DRAIN;
        end
        DRAIN: begin
          if (issue) begin
            if (last_addr) begin
              addr_reg <= '0;
              if (last_filter) begin
                state_reg <= FLUSH;
              end else begin
                filter_reg <= filter_reg + 1'b1;
              end
            end else begin
              addr_reg <= addr_reg + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (beat_accepted) begin
            state_reg <= DONE;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_drain_scheduler.sv
// Bench for output_drain_scheduler: vector table of drains, random drains and
// hand-written reset/restart sequences, all checked against a beat-index model.
module tb_output_drain_scheduler;

  localparam int NF  = 30;
  localparam int DAW = 18;
  localparam int BAW = 11;

  logic            clk_i = 1'b0;
  logic            bram_addr_max_rst = 1'b1;
  logic            start_i = 1'b0;
  logic [BAW-1:0]  addr_max_i = '0;
  logic [DAW-1:0]  dram_base_i = '0;
  logic            busy_o;
  logic            done_o;
  logic [4:0]      sel_filter_o;
  logic [1:0]      bram_rd_en_o;
  logic [BAW-1:0]  bram_rd_addr_o;
  logic            dram_wr_valid_o;
  logic            dram_wr_ready_i = 1'b0;
  logic [DAW-1:0]  dram_wr_addr_o;

  output_drain_scheduler dut (
    .clk_i            (clk_i),
    .bram_addr_max_rst(bram_addr_max_rst),
    .start_i          (start_i),
    .addr_max_i       (addr_max_i),
    .dram_base_i      (dram_base_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .sel_filter_o     (sel_filter_o),
    .bram_rd_en_o     (bram_rd_en_o),
    .bram_rd_addr_o   (bram_rd_addr_o),
    .dram_wr_valid_o  (dram_wr_valid_o),
    .dram_wr_ready_i  (dram_wr_ready_i),
    .dram_wr_addr_o   (dram_wr_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor state: the reference model derives everything from beat/issue index.
  bit             mon_en = 1'b0;
  int             mon_max = 0;
  logic [DAW-1:0] mon_base = '0;
  int             mon_beats, mon_issues, done_count;
  int             cyc = 0;
  int             start_cyc, first_valid_cyc, last_beat_cyc, done_cyc;
  bit             first_seen, prev_stall, busy_at_first;
  logic [DAW-1:0] prev_addr, last_addr_seen;
  logic [4:0]     prev_sel;

  always @(negedge clk_i) begin
    cyc++;
    if (mon_en) begin
      if (start_i && start_cyc < 0) start_cyc = cyc;
      if (dram_wr_valid_o && !first_seen) begin
        first_seen = 1'b1;
        first_valid_cyc = cyc;
        busy_at_first = busy_o;
      end
      if (dram_wr_valid_o && !dram_wr_ready_i) check("no_issue_while_stalled", 32'(bram_rd_en_o), 32'd0);
      if (bram_rd_en_o != 2'b00) begin
        int f, a;
        logic [1:0] exp_en;
        f = mon_issues / (mon_max + 1);
        a = mon_issues % (mon_max + 1);
        exp_en = (f < 16) ? 2'b01 : 2'b10;
        check("rd_en_bank", 32'(bram_rd_en_o), 32'(exp_en));
        check("rd_addr", 32'(bram_rd_addr_o), 32'(a));
        mon_issues++;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(dram_wr_valid_o), 32'd1);
        check("hold_addr", 32'(dram_wr_addr_o), 32'(prev_addr));
        check("hold_sel", 32'(sel_filter_o), 32'(prev_sel));
      end
      if (dram_wr_valid_o && dram_wr_ready_i) begin
        logic [DAW-1:0] exp_addr;
        exp_addr = mon_base + DAW'(mon_beats);
        check("beat_addr", 32'(dram_wr_addr_o), 32'(exp_addr));
        check("beat_sel", 32'(sel_filter_o), 32'(mon_beats / (mon_max + 1)));
        last_addr_seen = dram_wr_addr_o;
        last_beat_cyc = cyc;
        mon_beats++;
      end
      if (done_o) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_stall = dram_wr_valid_o && !dram_wr_ready_i;
      prev_addr = dram_wr_addr_o;
      prev_sel = sel_filter_o;
    end
  end

  function automatic logic ready_for(input int mode, input int t);
    logic [3:0] pat;
    pat = 4'b1001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[3 - (t % 4)];
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic arm_monitor(input int amax, input logic [DAW-1:0] base);
    mon_max = amax;
    mon_base = base;
    mon_beats = 0;
    mon_issues = 0;
    done_count = 0;
    start_cyc = -1;
    first_valid_cyc = -1;
    last_beat_cyc = -1;
    done_cyc = -1;
    first_seen = 1'b0;
    prev_stall = 1'b0;
    busy_at_first = 1'b0;
    last_addr_seen = '0;
    mon_en = 1'b1;
  endtask

  task automatic run_drain(input int amax, input logic [DAW-1:0] base, input int mode,
                           input bit poke, input int exp_beats, input logic [DAW-1:0] exp_last);
    int t;
    @(posedge clk_i); #1;
    arm_monitor(amax, base);
    addr_max_i = BAW'(amax);
    dram_base_i = base;
    start_i = 1'b1;
    dram_wr_ready_i = ready_for(mode, 0);
    t = 0;
    while (done_count == 0 && t < 5000) begin
      @(posedge clk_i); #1;
      t++;
      start_i = poke && (t == 20);
      if (t >= 2) begin
        addr_max_i = BAW'($urandom);
        dram_base_i = DAW'($urandom);
      end
      dram_wr_ready_i = ready_for(mode, t);
    end
    check("drain_finished", 32'(t < 5000), 32'd1);
    repeat (3) begin
      @(posedge clk_i); #1;
      dram_wr_ready_i = ready_for(mode, t);
    end
    mon_en = 1'b0;
    check("beat_count", 32'(mon_beats), 32'(exp_beats));
    check("issue_count", 32'(mon_issues), 32'(exp_beats));
    check("last_addr", 32'(last_addr_seen), 32'(exp_last));
    check("done_once", 32'(done_count), 32'd1);
    check("done_after_last", 32'(done_cyc - last_beat_cyc), 32'd1);
    check("start_to_valid", 32'(first_valid_cyc - start_cyc), 32'd3);
    check("busy_during", 32'(busy_at_first), 32'd1);
    check("busy_after", 32'(busy_o), 32'd0);
    $display("drain max=%0d base=0x%0h mode=%0d poke=%0d: beats=%0d last=0x%0h done=%0d",
             amax, base, mode, poke, mon_beats, last_addr_seen, done_count);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_valid"}, 32'(dram_wr_valid_o), 32'd0);
    check({tag, "_rd_en"}, 32'(bram_rd_en_o), 32'd0);
    check({tag, "_rd_addr"}, 32'(bram_rd_addr_o), 32'd0);
    check({tag, "_sel"}, 32'(sel_filter_o), 32'd0);
    check({tag, "_wr_addr"}, 32'(dram_wr_addr_o), 32'd0);
  endtask

  typedef struct {
    int             amax;
    logic [DAW-1:0] base;
    int             mode;
    bit             poke;
    int             exp_beats;
    logic [DAW-1:0] exp_last;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{amax: 3, base: 18'h00100, mode: 0, poke: 1'b0, exp_beats: 120, exp_last: 18'h00177};
    tbl[1] = '{amax: 1, base: 18'h02000, mode: 1, poke: 1'b0, exp_beats: 60,  exp_last: 18'h0203B};
    tbl[2] = '{amax: 0, base: 18'h00000, mode: 0, poke: 1'b0, exp_beats: 30,  exp_last: 18'h0001D};
    tbl[3] = '{amax: 0, base: 18'h3FFFE, mode: 0, poke: 1'b0, exp_beats: 30,  exp_last: 18'h0001B};
    tbl[4] = '{amax: 2, base: 18'h00055, mode: 2, poke: 1'b1, exp_beats: 90,  exp_last: 18'h000AE};

    #2;
    check_all_zero("reset");
    #10 bram_addr_max_rst = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check_all_zero("idle");

    for (int i = 0; i < 5; i++) begin
      run_drain(tbl[i].amax, tbl[i].base, tbl[i].mode, tbl[i].poke, tbl[i].exp_beats, tbl[i].exp_last);
    end

    for (int r = 0; r < 4; r++) begin
      int amax;
      logic [DAW-1:0] base;
      amax = $urandom_range(0, 4);
      base = DAW'($urandom);
      run_drain(amax, base, 2, r[0], NF * (amax + 1), base + DAW'(NF * (amax + 1) - 1));
    end

    // Asynchronous reset after ten beats, then a clean drain from the same base.
    begin
      int t;
      int late_done;
      @(posedge clk_i); #1;
      arm_monitor(3, 18'h00040);
      addr_max_i = BAW'(3);
      dram_base_i = 18'h00040;
      start_i = 1'b1;
      dram_wr_ready_i = 1'b1;
      t = 0;
      while (mon_beats < 10 && t < 200) begin
        @(posedge clk_i); #1;
        start_i = 1'b0;
        t++;
      end
      check("reach_beat10", 32'(mon_beats >= 10), 32'd1);
      #2 bram_addr_max_rst = 1'b1;
      mon_en = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk_i);
      #3 bram_addr_max_rst = 1'b0;
      late_done = 0;
      repeat (6) begin
        @(negedge clk_i);
        if (done_o || busy_o || dram_wr_valid_o) late_done++;
      end
      check("no_activity_after_abort", 32'(late_done), 32'd0);
      $display("reset at beat %0d: outputs cleared, no done", mon_beats);
      run_drain(3, 18'h00040, 0, 1'b0, 120, 18'h000B7);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
